// File: rtl/mio_bus_pkg.sv
// rtl/mio_bus_pkg.sv - shared encodings and helpers for the MIO bus unit
package mio_bus_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mio_bus_unit_if.sv
// rtl/mio_bus_unit_if.sv - MIO bus between the access engine and memory/peripherals
interface mio_bus_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   Addr_out;
    logic [DATA_W-1:0]   Data_out;
    logic [DATA_W/8-1:0] be;
    logic                mem_w;
    logic                CPU_MIO;
    logic                MIO_ready;
    logic [DATA_W-1:0]   Data_in;

    modport master (
        output Addr_out, Data_out, be, mem_w, CPU_MIO,
        input  MIO_ready, Data_in
    );

    modport slave (
        input  Addr_out, Data_out, be, mem_w, CPU_MIO,
        output MIO_ready, Data_in
    );
endinterface

// File: rtl/mio_lane_align.sv
// rtl/mio_lane_align.sv - byte-lane enables, write replication and read extraction
module mio_lane_align
    import mio_bus_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = lane_bits(DATA_W)
) (
    input  logic [1:0]        size,
    input  logic [LB-1:0]     lane,
    input  logic              signed_rd,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_bus,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] rdata_ext
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              msb;

    always_comb begin
        be       = '0;
        data_out = '0;
        case (size)
            SZ_BYTE: begin
                be       = NB'(1) << lane;
                data_out = {NB{wdata[7:0]}};
            end
            SZ_HALF: begin
                be       = NB'(2'b11) << lane;
                data_out = {(NB/2){wdata[15:0]}};
            end
            SZ_WORD: begin
                be       = NB'(4'hF) << lane;
                data_out = {(NB/4){wdata[31:0]}};
            end
            default: begin
                be       = '1;
                data_out = wdata;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, keep the access width, then extend.
    always_comb begin
        shifted = rdata_bus >> {lane, 3'b000};
        keep    = '1;
        msb     = shifted[DATA_W-1];
        case (size)
            SZ_BYTE: begin
                keep = DATA_W'(8'hFF);
                msb  = shifted[7];
            end
            SZ_HALF: begin
                keep = DATA_W'(16'hFFFF);
                msb  = shifted[15];
            end
            SZ_WORD: begin
                keep = DATA_W'(32'hFFFF_FFFF);
                msb  = shifted[31];
            end
            default: begin
                keep = '1;
                msb  = shifted[DATA_W-1];
            end
        endcase
        rdata_ext = (shifted & keep) | ((signed_rd && msb) ? ~keep : '0);
    end

endmodule

// File: rtl/mio_bus_unit.sv
// rtl/mio_bus_unit.sv - sequenced single-access engine between the CPU FSM and the MIO bus
module mio_bus_unit
    import mio_bus_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    mio_bus_unit_if.master    mio
);
    localparam int NB    = DATA_W / 8;
    localparam int LB    = lane_bits(DATA_W);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ACCESS);
    localparam logic [1:0] S_RESP   = 2'(RESP);

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;

    logic              misaligned;
    logic              in_access;
    logic [NB-1:0]     be_lane;
    logic [DATA_W-1:0] dout_lane;
    logic [DATA_W-1:0] rdata_ext;

    // Illegal requests are rejected before any bus cycle starts.
    always_comb begin
        misaligned = 1'b0;
        case (cpu_size)
            SZ_HALF:  misaligned = cpu_addr[0];
            SZ_WORD:  misaligned = |cpu_addr[1:0];
            SZ_DWORD: misaligned = (DATA_W == 32) || (|cpu_addr[2:0]);
            default:  misaligned = 1'b0;
        endcase
    end

    mio_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .size      (size_q),
        .lane      (addr_q[LB-1:0]),
        .signed_rd (signed_q),
        .wdata     (wdata_q),
        .rdata_bus (mio.Data_in),
        .be        (be_lane),
        .data_out  (dout_lane),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q   <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        we_q     <= cpu_we;
                        size_q   <= cpu_size;
                        signed_q <= cpu_signed;
                        err_q    <= misaligned;
                        cnt_q    <= '0;
                        state_q  <= misaligned ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Ready takes priority over a timeout expiring on the same edge.
                    if (mio.MIO_ready) begin
                        if (!we_q) begin
                            rdata_q <= rdata_ext;
                        end
                        err_q   <= 1'b0;
                        state_q <= S_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state_q == S_ACCESS);

    assign cpu_rdata = rdata_q;
    assign cpu_done  = (state_q == S_RESP);
    assign cpu_err   = (state_q == S_RESP) && err_q;
    assign cpu_busy  = (state_q != S_IDLE);

    assign mio.CPU_MIO  = in_access;
    assign mio.mem_w    = in_access && we_q;
    assign mio.be       = in_access ? be_lane : '0;
    assign mio.Data_out = in_access ? dout_lane : '0;
    assign mio.Addr_out = in_access ? {addr_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;

endmodule

// File: tb/tb_mio_bus_unit.sv
// tb/tb_mio_bus_unit.sv - scoreboard bench for mio_bus_unit at 32- and 64-bit widths
module tb_mio_bus_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic        we, sgn, ready;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata, din;

    logic [31:0] rdata0;
    logic [63:0] rdata1;
    logic        done0, err0, busy0;
    logic        done1, err1, busy1;

    int checks = 0;
    int errors = 0;

    logic [64:0] q0[$];
    logic [64:0] q1[$];

    always #5 clk = ~clk;

    mio_bus_unit_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    mio_bus_unit_if #(.DATA_W(64), .ADDR_W(32)) bus1 ();

    assign bus0.MIO_ready = ready;
    assign bus0.Data_in   = din[31:0];
    assign bus1.MIO_ready = ready;
    assign bus1.Data_in   = din;

    mio_bus_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut32 (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (req0),
        .cpu_we     (we),
        .cpu_size   (size),
        .cpu_signed (sgn),
        .cpu_addr   (addr),
        .cpu_wdata  (wdata[31:0]),
        .cpu_rdata  (rdata0),
        .cpu_done   (done0),
        .cpu_err    (err0),
        .cpu_busy   (busy0),
        .mio        (bus0)
    );

    mio_bus_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(4)) dut64 (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (req1),
        .cpu_we     (we),
        .cpu_size   (size),
        .cpu_signed (sgn),
        .cpu_addr   (addr),
        .cpu_wdata  (wdata),
        .cpu_rdata  (rdata1),
        .cpu_done   (done1),
        .cpu_err    (err1),
        .cpu_busy   (busy1),
        .mio        (bus1)
    );

    // Observed view of whichever DUT the current stimulus targets.
    logic        sel;
    logic [63:0] m_rdata, m_dout;
    logic [31:0] m_addr;
    logic [7:0]  m_be;
    logic        m_done, m_err, m_busy, m_mio, m_memw;

    assign m_rdata = sel ? rdata1 : {32'b0, rdata0};
    assign m_dout  = sel ? bus1.Data_out : {32'b0, bus0.Data_out};
    assign m_addr  = sel ? bus1.Addr_out : bus0.Addr_out;
    assign m_be    = sel ? bus1.be : {4'b0, bus0.be};
    assign m_done  = sel ? done1 : done0;
    assign m_err   = sel ? err1 : err0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_mio   = sel ? bus1.CPU_MIO : bus0.CPU_MIO;
    assign m_memw  = sel ? bus1.mem_w : bus0.mem_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (done0) begin
            if (q0.size() == 0) begin
                chk("dut32 unexpected done", 64'(done0), 64'd0);
            end else begin
                e = q0.pop_front();
                chk("dut32 cpu_err", 64'(err0), 64'(e[64]));
                chk("dut32 cpu_rdata", {32'b0, rdata0}, e[63:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (done1) begin
            if (q1.size() == 0) begin
                chk("dut64 unexpected done", 64'(done1), 64'd0);
            end else begin
                e = q1.pop_front();
                chk("dut64 cpu_err", 64'(err1), 64'(e[64]));
                chk("dut64 cpu_rdata", rdata1, e[63:0]);
            end
        end
    end

    task automatic check_idle(input string name, input logic d);
        sel = d;
        #1;
        chk({name, " done"}, 64'(m_done), 64'd0);
        chk({name, " err"}, 64'(m_err), 64'd0);
        chk({name, " busy"}, 64'(m_busy), 64'd0);
        chk({name, " CPU_MIO"}, 64'(m_mio), 64'd0);
        chk({name, " mem_w"}, 64'(m_memw), 64'd0);
        chk({name, " be"}, 64'(m_be), 64'd0);
        chk({name, " Addr_out"}, 64'(m_addr), 64'd0);
        chk({name, " Data_out"}, m_dout, 64'd0);
        chk({name, " rdata"}, m_rdata, 64'd0);
    endtask

    // wait_n: ACCESS cycles with ready low before ready is raised; -1 never raises it.
    task automatic run_access(input string name, input logic d, input logic w, input logic [1:0] sz,
                              input logic s, input logic [31:0] a, input logic [63:0] wd,
                              input logic [63:0] di, input int wait_n, input logic [31:0] e_addr,
                              input logic [7:0] e_be, input logic [63:0] e_dout, input logic e_err,
                              input logic [63:0] e_rdata, input int e_lat, input int e_acc);
        int k, acc, memw_n;
        bit done_seen;
        @(negedge clk);
        sel = d; we = w; size = sz; sgn = s; addr = a; wdata = wd; din = di; ready = 1'b0;
        if (d) begin
            req1 = 1'b1;
            q1.push_back({e_err, e_rdata});
        end else begin
            req0 = 1'b1;
            q0.push_back({e_err, e_rdata});
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        acc = 0; memw_n = 0; done_seen = 0; k = 0;
        while (!done_seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) chk({name, " busy"}, 64'(m_busy), 64'd1);
            if (m_mio) begin
                acc++;
                if (m_memw) memw_n++;
                if (acc == 1) begin
                    chk({name, " Addr_out"}, 64'(m_addr), 64'(e_addr));
                    chk({name, " be"}, 64'(m_be), 64'(e_be));
                    if (w) chk({name, " Data_out"}, m_dout, e_dout);
                end
                ready = (acc - 1 == wait_n);
            end else begin
                ready = 1'b0;
            end
            if (m_done) begin
                done_seen = 1;
                chk({name, " done latency"}, 64'(k), 64'(e_lat));
            end
        end
        ready = 1'b0;
        chk({name, " done seen"}, 64'(done_seen), 64'd1);
        chk({name, " access cycles"}, 64'(acc), 64'(e_acc));
        chk({name, " mem_w cycles"}, 64'(memw_n), w ? 64'(e_acc) : 64'd0);
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we = 1'b0; sgn = 1'b0; ready = 1'b0;
        size = 2'd0; addr = '0; wdata = '0; din = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset32", 1'b0);
        check_idle("reset64", 1'b1);
        reset = 1'b0;

        //          name        d  w     sz     s  addr        wdata            Data_in                 wt  e_addr      e_be   e_dout                 er  e_rdata                 lat acc
        run_access("rd_word",   0, 0, 2'd2, 0, 32'h1004, 64'h0,          64'hDEADBEEF,          0, 32'h1004, 8'hF, 64'h0,                0, 64'hDEADBEEF,          2, 1);
        run_access("rd_sbyte",  0, 0, 2'd0, 1, 32'h2003, 64'h0,          64'h80FF0000,          0, 32'h2000, 8'h8, 64'h0,                0, 64'hFFFFFF80,          2, 1);
        run_access("rd_ubyte",  0, 0, 2'd0, 0, 32'h2003, 64'h0,          64'h80FF0000,          0, 32'h2000, 8'h8, 64'h0,                0, 64'h00000080,          2, 1);
        run_access("wr_half",   0, 1, 2'd1, 0, 32'h3002, 64'h0000ABCD,   64'h0,                 3, 32'h3000, 8'hC, 64'hABCDABCD,         0, 64'h00000080,          5, 4);
        run_access("misalign",  0, 0, 2'd2, 0, 32'h4002, 64'h0,          64'h0,                 0, 32'h0,    8'h0, 64'h0,                1, 64'h00000080,          1, 0);
        run_access("dword32",   0, 0, 2'd3, 0, 32'h5000, 64'h0,          64'h0,                 0, 32'h0,    8'h0, 64'h0,                1, 64'h00000080,          1, 0);
        run_access("timeout",   0, 0, 2'd2, 0, 32'h6000, 64'h0,          64'h11111111,         -1, 32'h6000, 8'hF, 64'h0,                1, 64'h00000080,          5, 4);
        run_access("ready_last",0, 0, 2'd2, 0, 32'h6000, 64'h0,          64'h12345678,          3, 32'h6000, 8'hF, 64'h0,                0, 64'h12345678,          5, 4);
        run_access("rd_shalf",  0, 0, 2'd1, 1, 32'h7002, 64'h0,          64'h80011234,          0, 32'h7000, 8'hC, 64'h0,                0, 64'hFFFF8001,          2, 1);
        run_access("wr_byte",   0, 1, 2'd0, 0, 32'h7001, 64'h000000A5,   64'h0,                 1, 32'h7000, 8'h2, 64'hA5A5A5A5,         0, 64'hFFFF8001,          3, 2);

        // Reset in the second ACCESS cycle aborts the access without a completion.
        @(negedge clk);
        sel = 1'b0; we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h1000; din = 64'hCAFEF00D; req0 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid in access", 64'(m_mio), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("rst_mid", 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_access("after_rst", 0, 0, 2'd2, 0, 32'h1000, 64'h0,          64'hCAFEF00D,          0, 32'h1000, 8'hF, 64'h0,                0, 64'hCAFEF00D,          2, 1);

        run_access("rd_dword",  1, 0, 2'd3, 0, 32'h0008, 64'h0,          64'h0123456789ABCDEF,  0, 32'h0008, 8'hFF, 64'h0,               0, 64'h0123456789ABCDEF,  2, 1);
        run_access("rd_sword64",1, 0, 2'd2, 1, 32'h000C, 64'h0,          64'h8000000000000000,  0, 32'h0008, 8'hF0, 64'h0,               0, 64'hFFFFFFFF80000000,  2, 1);
        run_access("mis_dword", 1, 0, 2'd3, 0, 32'h0004, 64'h0,          64'h0,                 0, 32'h0,    8'h0,  64'h0,               1, 64'hFFFFFFFF80000000,  1, 0);
        run_access("wr_byte64", 1, 1, 2'd0, 0, 32'h0005, 64'h3C,         64'h0,                 1, 32'h0000, 8'h20, 64'h3C3C3C3C3C3C3C3C, 0, 64'hFFFFFFFF80000000,  3, 2);

        repeat (2) @(negedge clk);
        chk("dut32 pending completions", 64'(q0.size()), 64'd0);
        chk("dut64 pending completions", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
